// File: rtl/gray_serial_dec_pkg.sv
// gray_dec_pkg: shared FSM state, counter sizing and Gray reference decode for gray_serial_dec.
package gray_dec_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

   function automatic int cnt_width(input int n);
      return $clog2(n + 2);
   endfunction

   function automatic logic [63:0] gray2bin(input logic [63:0] g, input int n);
      logic [63:0] b;
      b = '0;
      for (int i = n - 1; i >= 0; i--) b[i] = g[i] ^ ((i == n - 1) ? 1'b0 : b[i + 1]);
      return b;
   endfunction

endpackage

// File: rtl/gray_serial_dec_if.sv
// gray_serial_dec_if: serial Gray input beat and decoded word output handshake bundle.
interface gray_serial_dec_if #(parameter int N = 8);

   logic          clr;
   logic          in_valid;
   logic          in_bit;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  dout;
   logic [N-1:0]  dout_gray;
   logic          parity_err;
   logic          busy;

   modport master (
      output clr, in_valid, in_bit, out_ready,
      input  in_ready, out_valid, dout, dout_gray, parity_err, busy
   );

   modport slave (
      input  clr, in_valid, in_bit, out_ready,
      output in_ready, out_valid, dout, dout_gray, parity_err, busy
   );

endinterface

// File: rtl/gray_serial_dec_out_reg.sv
// gray_dec_out_reg: holds a completed word until the consumer retires it; clr drops valid only.
module gray_dec_out_reg #(
   parameter int N = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          load_i,
   input  logic          ready_i,
   input  logic          perr_i,
   input  logic [N-1:0]  bin_i,
   input  logic [N-1:0]  gray_i,
   output logic          valid_o,
   output logic          perr_o,
   output logic [N-1:0]  dout_o,
   output logic [N-1:0]  gray_o
);

   logic          valid_q, valid_d;
   logic          perr_q, perr_d;
   logic [N-1:0]  dout_q, dout_d;
   logic [N-1:0]  gray_q, gray_d;

   always_comb begin
      valid_d = clr_i ? 1'b0 : (load_i || (valid_q && !ready_i));
      perr_d  = load_i ? perr_i : perr_q;
      dout_d  = load_i ? bin_i : dout_q;
      gray_d  = load_i ? gray_i : gray_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         dout_q  <= '0;
         gray_q  <= '0;
      end else begin
         valid_q <= valid_d;
         perr_q  <= perr_d;
         dout_q  <= dout_d;
         gray_q  <= gray_d;
      end
   end

   assign valid_o = valid_q;
   assign perr_o  = perr_q;
   assign dout_o  = dout_q;
   assign gray_o  = gray_q;

endmodule

// File: rtl/gray_serial_dec.sv
// gray_serial_dec: bit-serial MSB-first Gray-to-binary decoder with a valid/ready word output.
// Define GRAY_SERIAL_PARITY_EN to expect a trailing even-parity bit after every N Gray bits.
module gray_serial_dec
   import gray_dec_pkg::*;
#(
   parameter int N = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   gray_serial_dec_if.slave bus
);

   localparam int CW = cnt_width(N);

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   gray_q, gray_d;
   logic [N-1:0]   bin_q, bin_d;
   logic           run_q, run_d;
   logic           accept, first, last, load, b, data_bit, perr;

`ifdef GRAY_SERIAL_PARITY_EN
   localparam int BEATS = N + 1;
   logic par_q, par_d;
   assign data_bit = (state_q != SHIFT) || (cnt_q < CW'(N));
   assign par_d    = (accept && !bus.clr) ? ((par_q && !first) ^ bus.in_bit) : par_q;
   assign perr     = par_d;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_q <= 1'b0;
      else        par_q <= par_d;
   end
`else
   localparam int BEATS = N;
   assign data_bit = 1'b1;
   assign perr     = 1'b0;
`endif

   assign bus.in_ready = (state_q != HOLD) || bus.out_ready;
   assign bus.busy     = state_q == SHIFT;
   assign accept       = bus.in_valid && bus.in_ready;
   assign first        = state_q != SHIFT;
   assign last         = (state_q == SHIFT) && (cnt_q == CW'(BEATS - 1));
   assign load         = accept && last && !bus.clr;
   // first bit of a word decodes against an implicit 0 above the MSB
   assign b            = bus.in_bit ^ (run_q && !first);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gray_d  = gray_q;
      bin_d   = bin_q;
      run_d   = run_q;
      if (bus.clr) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (accept) begin
         gray_d  = data_bit ? {gray_q[N-2:0], bus.in_bit} : gray_q;
         bin_d   = data_bit ? {bin_q[N-2:0], b} : bin_q;
         run_d   = data_bit ? b : run_q;
         state_d = last ? HOLD : SHIFT;
         cnt_d   = last ? '0 : (first ? CW'(1) : cnt_q + CW'(1));
      end else if (state_q == HOLD && bus.out_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gray_q  <= '0;
         bin_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gray_q  <= gray_d;
         bin_q   <= bin_d;
         run_q   <= run_d;
      end
   end

   gray_dec_out_reg #(.N(N)) u_out (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (bus.clr),
      .load_i  (load),
      .ready_i (bus.out_ready),
      .perr_i  (perr),
      .bin_i   (bin_d),
      .gray_i  (gray_d),
      .valid_o (bus.out_valid),
      .perr_o  (bus.parity_err),
      .dout_o  (bus.dout),
      .gray_o  (bus.dout_gray)
   );

endmodule
